// File: rtl/div_unit_if.sv
// Request/result bundle between a requester and the signed divider.
// The requester drives the operands; the divider returns HI/LO results and status.
interface div_unit_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output start, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Signed 32-bit restoring divider with MIPS DIV semantics.
// Produces the quotient on lo and the remainder on hi, 34 cycles after a start is accepted.
module div_unit (
    input  logic      clk,
    input  logic      reset,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        FINISH
    } state_t;

    state_t      state;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [4:0]  cnt;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        dz_q;

    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] shifted;
    logic [32:0] diff;

    assign a_abs   = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
    assign b_abs   = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
    assign shifted = {rem, quo[31]};
    // Remainder stays below the divisor, so a clear bit 32 means no borrow.
    assign diff    = shifted - {1'b0, dvs};

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    dz_q   <= 1'b0;
                    if (bus.start) begin
                        if (bus.b == 32'd0) begin
                            done_q <= 1'b1;
                            dz_q   <= 1'b1;
                            state  <= FINISH;
                        end else begin
                            quo    <= a_abs;
                            dvs    <= b_abs;
                            rem    <= '0;
                            cnt    <= '0;
                            neg_r  <= bus.a[31];
                            neg_q  <= bus.a[31] ^ bus.b[31];
                            busy_q <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!diff[32]) begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= shifted[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo_q   <= neg_q ? (~quo + 32'd1) : quo;
                    hi_q   <= neg_r ? (~rem + 32'd1) : rem;
                    done_q <= 1'b1;
                    state  <= FINISH;
                end
                FINISH: begin
                    done_q <= 1'b0;
                    dz_q   <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit.
// Expected quotients and remainders are hand-computed from MIPS DIV rules.
module tb_div_unit;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   done_at;
    int   busy_n;
    logic dz_seen;
    int   late_done;

    div_unit_if bus ();

    div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one request for 40 cycles; poke re-pulses start with 1/1 at that cycle.
    task automatic op(input logic [31:0] va, input logic [31:0] vb, input int poke);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = va;
        bus.b     = vb;
        done_at   = 0;
        busy_n    = 0;
        dz_seen   = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.done && done_at == 0) begin
                done_at = n;
                dz_seen = bus.div_zero;
            end
            if (n == poke) begin
                bus.start = 1'b1;
                bus.a     = 32'd1;
                bus.b     = 32'd1;
            end
            if (n == poke + 1) bus.start = 1'b0;
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_dz", 32'(bus.div_zero), 32'h0);

        op(32'd7, 32'd2, 0);
        chk("p7_2_done_at", 32'(done_at), 32'd34);
        chk("p7_2_busy_n", 32'(busy_n), 32'd34);
        chk("p7_2_lo", bus.lo, 32'h00000003);
        chk("p7_2_hi", bus.hi, 32'h00000001);
        chk("p7_2_dz", 32'(dz_seen), 32'h0);

        op(32'hFFFFFFF9, 32'd2, 0);
        chk("n7_2_lo", bus.lo, 32'hFFFFFFFD);
        chk("n7_2_hi", bus.hi, 32'hFFFFFFFF);

        op(32'd7, 32'hFFFFFFFE, 0);
        chk("p7_n2_lo", bus.lo, 32'hFFFFFFFD);
        chk("p7_n2_hi", bus.hi, 32'h00000001);

        op(32'h12345678, 32'h0, 0);
        chk("dz_done_at", 32'(done_at), 32'd1);
        chk("dz_flag", 32'(dz_seen), 32'h1);
        chk("dz_busy_n", 32'(busy_n), 32'd0);
        chk("dz_lo_kept", bus.lo, 32'hFFFFFFFD);
        chk("dz_hi_kept", bus.hi, 32'h00000001);

        op(32'h80000000, 32'hFFFFFFFF, 0);
        chk("ovf_lo", bus.lo, 32'h80000000);
        chk("ovf_hi", bus.hi, 32'h00000000);
        chk("ovf_dz", 32'(dz_seen), 32'h0);
        chk("ovf_done_at", 32'(done_at), 32'd34);

        op(32'd100, 32'd7, 10);
        chk("ign_done_at", 32'(done_at), 32'd34);
        chk("ign_lo", bus.lo, 32'd14);
        chk("ign_hi", bus.hi, 32'd2);

        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
        end
        chk("abort_busy_pre", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_hi", bus.hi, 32'h0);
        chk("abort_lo", bus.lo, 32'h0);
        late_done = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.done) late_done++;
        end
        chk("abort_no_done", 32'(late_done), 32'd0);

        op(32'd9, 32'd3, 0);
        chk("post_lo", bus.lo, 32'd3);
        chk("post_hi", bus.hi, 32'd0);
        chk("post_done_at", 32'(done_at), 32'd34);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
